alu_sched: RTL and testbench



---
 rtl/alu_sched.sv | 136 +++++++++++++
 tb/tb_alu_sched.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
// Two-requester scheduler for the shared 64-bit Y86 ALU with a 1-entry result buffer and condition codes.
// Define ALU_SCHED_STRICT_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_sched #(
    parameter int W    = 64,
    parameter int ID_W = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [1:0]      req0_op,
    input  logic [W-1:0]    req0_a,
    input  logic [W-1:0]    req0_b,
    input  logic            req0_set_cc,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [1:0]      req1_op,
    input  logic [W-1:0]    req1_a,
    input  logic [W-1:0]    req1_b,
    input  logic            req1_set_cc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_result,
    output logic            out_ovf,
    output logic [ID_W-1:0] out_id,
    output logic            cc_zf,
    output logic            cc_sf,
    output logic            cc_of
);

    typedef enum logic {EMPTY, FULL} buf_state_t;

    buf_state_t state, state_nxt;

    logic         space;
    logic         grant0, grant1;
    logic         accept;
    logic [1:0]   sel_op;
    logic [W-1:0] sel_a, sel_b;
    logic         sel_set_cc;
    logic [W-1:0] alu_r;
    logic         alu_ovf;

    assign space = (state == EMPTY) | out_ready;

`ifdef ALU_SCHED_STRICT_PRIO_EN
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid & ~req0_valid;
    end
`else
    logic last_grant;

    // On a tie the requester that did not win last time gets the slot.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_grant);
        grant1 = req1_valid & (~req0_valid | ~last_grant);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= grant1;
    end
`endif

    assign req0_ready = grant0 & space;
    assign req1_ready = grant1 & space;
    assign accept     = (grant0 | grant1) & space;

    always_comb begin
        sel_op     = grant1 ? req1_op     : req0_op;
        sel_a      = grant1 ? req1_a      : req0_a;
        sel_b      = grant1 ? req1_b      : req0_b;
        sel_set_cc = grant1 ? req1_set_cc : req0_set_cc;
    end

    // Overflow only exists for ADD/SUB: result sign differs from a sign-consistent operand pair.
    always_comb begin
        alu_r   = '0;
        alu_ovf = 1'b0;
        case (sel_op)
            2'd0: begin
                alu_r   = sel_a + sel_b;
                alu_ovf = (sel_a[W-1] == sel_b[W-1]) & (alu_r[W-1] != sel_a[W-1]);
            end
            2'd1: begin
                alu_r   = sel_a - sel_b;
                alu_ovf = (sel_a[W-1] != sel_b[W-1]) & (alu_r[W-1] != sel_a[W-1]);
            end
            2'd2: alu_r = sel_a & sel_b;
            default: alu_r = sel_a ^ sel_b;
        endcase
    end

    always_comb begin
        state_nxt = state;
        out_valid = (state == FULL);
        case (state)
            EMPTY: if (accept) state_nxt = FULL;
            FULL: begin
                if (accept)
                    state_nxt = FULL;
                else if (out_ready)
                    state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= EMPTY;
            out_result <= '0;
            out_ovf    <= 1'b0;
            out_id     <= '0;
            cc_zf      <= 1'b1;
            cc_sf      <= 1'b0;
            cc_of      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                out_result <= alu_r;
                out_ovf    <= alu_ovf;
                out_id     <= ID_W'(grant1);
                if (sel_set_cc) begin
                    cc_zf <= (alu_r == '0);
                    cc_sf <= alu_r[W-1];
                    cc_of <= alu_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// Randomized self-checking bench for alu_sched against a cycle-level behavioural model.
// Honours ALU_SCHED_STRICT_PRIO_EN in the model when the design is built with it.
module tb_alu_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_set_cc;
    logic [1:0]  req0_op;
    logic [63:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_set_cc;
    logic [1:0]  req1_op;
    logic [63:0] req1_a, req1_b;
    logic        out_valid, out_ready, out_ovf;
    logic [63:0] out_result;
    logic [0:0]  out_id;
    logic        cc_zf, cc_sf, cc_of;

    int total = 0;
    int bad   = 0;

    logic        m_full, m_ovf, m_id, m_zf, m_sf, m_of, m_last;
    logic [63:0] m_res;

    always #5 clk = ~clk;

    alu_sched #(.W(64), .ID_W(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_set_cc(req0_set_cc),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_set_cc(req1_set_cc),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_ovf(out_ovf), .out_id(out_id),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference ALU: overflow means the exact signed result does not fit in 64 bits.
    task automatic modelAlu(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                            output logic [63:0] r, output logic o);
        logic signed [64:0] exact;
        o = 1'b0;
        case (op)
            2'd0: begin
                exact = $signed({a[63], a}) + $signed({b[63], b});
                r = a + b;
                o = (exact != $signed({r[63], r}));
            end
            2'd1: begin
                exact = $signed({a[63], a}) - $signed({b[63], b});
                r = a - b;
                o = (exact != $signed({r[63], r}));
            end
            2'd2: r = a & b;
            default: r = a ^ b;
        endcase
    endtask

    task automatic modelReset();
        m_full = 0; m_res = 0; m_ovf = 0; m_id = 0;
        m_zf = 1; m_sf = 0; m_of = 0; m_last = 1;
    endtask

    // One clock cycle: drive inputs, check outputs and readies, then advance the model.
    task automatic applyStimulus(
        input logic v0, input logic [1:0] o0, input logic [63:0] a0, input logic [63:0] b0, input logic c0,
        input logic v1, input logic [1:0] o1, input logic [63:0] a1, input logic [63:0] b1, input logic c1,
        input logic ordy, input logic rn);
        logic        winner, has_winner, space, op_ovf;
        logic [63:0] op_r;
        @(negedge clk);
        req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0; req0_set_cc = c0;
        req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1; req1_set_cc = c1;
        out_ready = ordy; rst_n = rn;
        #1;
        checkOutput("out_valid", out_valid, m_full);
        checkOutput("out_result", out_result, m_res);
        checkOutput("out_ovf", out_ovf, m_ovf);
        checkOutput("out_id", out_id, m_id);
        checkOutput("cc", {cc_zf, cc_sf, cc_of}, {m_zf, m_sf, m_of});

        space = !m_full || ordy;
        has_winner = v0 || v1;
        if (v0 && v1) begin
`ifdef ALU_SCHED_STRICT_PRIO_EN
            winner = 0;
`else
            winner = (m_last == 0) ? 1'b1 : 1'b0;
`endif
        end else begin
            winner = v1 ? 1'b1 : 1'b0;
        end
        checkOutput("req0_ready", req0_ready, has_winner && space && winner == 0);
        checkOutput("req1_ready", req1_ready, has_winner && space && winner == 1);

        if (!rn) begin
            modelReset();
        end else if (has_winner && space) begin
            if (winner == 0) modelAlu(o0, a0, b0, op_r, op_ovf);
            else             modelAlu(o1, a1, b1, op_r, op_ovf);
            m_full = 1; m_res = op_r; m_ovf = op_ovf; m_id = winner; m_last = winner;
            if ((winner == 0) ? c0 : c1) begin
                m_zf = (op_r == 0); m_sf = op_r[63]; m_of = op_ovf;
            end
        end else if (m_full && ordy) begin
            m_full = 0;
        end
    endtask

    task automatic idleCycle(input logic ordy);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ordy, 1);
    endtask

    function automatic logic [63:0] randOperand();
        case ($urandom_range(0, 5))
            0: return 64'h0;
            1: return 64'h8000_0000_0000_0000;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        rst_n = 0; out_ready = 0;
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0; req0_set_cc = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0; req1_set_cc = 0;
        repeat (2) @(posedge clk);
        modelReset();

        idleCycle(1);
        applyStimulus(1, 1, 64'd19, 64'd10, 1, 0, 0, 0, 0, 0, 1, 1);
        idleCycle(1);
        checkOutput("sub19_10", out_result, 64'd9);

        applyStimulus(1, 1, 64'h8000_0000_0000_0000, 64'd1, 1, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(1, 3, 64'd5, 64'd5, 0, 0, 0, 0, 0, 0, 1, 1);
        idleCycle(1);

        for (int i = 0; i < 6; i++)
            applyStimulus(1, 2'($urandom), randOperand(), randOperand(), 1,
                          1, 2'($urandom), randOperand(), randOperand(), 1, 1, 1);
        idleCycle(1);

        applyStimulus(1, 0, 64'd1, 64'd2, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 0, 64'd7, 64'd7, 1, 1, 1, 64'd9, 64'd4, 1, 0, 1);
        applyStimulus(1, 0, 64'd7, 64'd7, 1, 1, 1, 64'd9, 64'd4, 1, 1, 1);
        idleCycle(1);

        applyStimulus(1, 1, 64'd3, 64'd3, 1, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 1, 64'd1, 64'd5, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 64'd4, 64'd4, 0, 1, 0, 64'd6, 64'd6, 0, 1, 1);
        idleCycle(1);
        checkOutput("tie_after_reset", out_id, 64'd0);

        applyStimulus(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1, 0, 0, 0, 0, 0, 1, 1);
        idleCycle(1);
        checkOutput("add_wrap_zf", {cc_zf, cc_sf, out_result == 0}, {1'b1, 1'b0, 1'b1});

        for (int i = 0; i < 400; i++)
            applyStimulus($urandom_range(0, 3) != 0, 2'($urandom), randOperand(), randOperand(), 1'($urandom),
                          $urandom_range(0, 3) != 0, 2'($urandom), randOperand(), randOperand(), 1'($urandom),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 40) != 0);
        idleCycle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
